// File: rtl/bank_cmd_arbiter_if.sv
// Request/grant bundle between the per-bank controllers, the arbiter and the issue FIFO.
// The master side drives requests and the FIFO-full flag; the slave (arbiter) drives grants and pushes.
interface bank_cmd_arbiter_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = 14
);
  logic [NUM_BANKS-1:0]           req_valid;
  logic [3*NUM_BANKS-1:0]         req_cmd;
  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr;
  logic                           isu_fifo_full;
  logic [NUM_BANKS-1:0]           grant;
  logic                           sch_issue;
  logic [ADDR_BITS+5:0]           sch_out;

  modport master (
    output req_valid, req_cmd, req_addr, isu_fifo_full,
    input  grant, sch_issue, sch_out
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, isu_fifo_full,
    output grant, sch_issue, sch_out
  );
endinterface

// File: rtl/bank_cmd_arbiter.sv
// Multi-bank command arbiter: refresh-first, otherwise round-robin among banks that meet
// tRRD/tFAW/tCCD, registering the winner into the issue-FIFO word {cmd, addr, bank}.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module bank_cmd_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = `ADDR_BITS,
  parameter int T_RRD     = 4,
  parameter int T_FAW     = 20,
  parameter int T_CCD     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bank_cmd_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ATCMD_NOP       = 3'd0,
    ATCMD_ACTIVE    = 3'd1,
    ATCMD_READ      = 3'd2,
    ATCMD_WRITE     = 3'd3,
    ATCMD_RDA       = 3'd4,
    ATCMD_WRA       = 3'd5,
    ATCMD_PRECHARGE = 3'd6,
    ATCMD_REFRESH   = 3'd7
  } sch_cmd_t;

  localparam int PW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int T_MAX = (T_FAW > T_RRD) ? ((T_FAW > T_CCD) ? T_FAW : T_CCD)
                                         : ((T_RRD > T_CCD) ? T_RRD : T_CCD);
  localparam int CW    = $clog2(T_MAX + 1);

  logic [PW-1:0]        rr_ptr;
  logic [CW-1:0]        rrd_cnt;
  logic [CW-1:0]        ccd_cnt;
  logic [CW-1:0]        faw_slot [4];

  sch_cmd_t             cmd [NUM_BANKS];
  logic [NUM_BANKS-1:0] eligible;
  logic [NUM_BANKS-1:0] is_ref;
  logic [NUM_BANKS-1:0] is_nop;
  logic                 faw_free;
  int                   faw_sel;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    faw_free = 1'b0;
    faw_sel  = 0;
    for (int s = 3; s >= 0; s--) begin
      if (faw_slot[s] == '0) begin
        faw_free = 1'b1;
        faw_sel  = s;
      end
    end

    eligible = '0;
    is_ref   = '0;
    is_nop   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cmd[i]    = sch_cmd_t'(bus.req_cmd[3*i +: 3]);
      is_ref[i] = (cmd[i] == ATCMD_REFRESH);
      is_nop[i] = (cmd[i] == ATCMD_NOP);
      case (cmd[i])
        ATCMD_ACTIVE:
          eligible[i] = bus.req_valid[i] && (rrd_cnt == '0) && faw_free;
        ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA:
          eligible[i] = bus.req_valid[i] && (ccd_cnt == '0);
        ATCMD_PRECHARGE, ATCMD_REFRESH:
          eligible[i] = bus.req_valid[i];
        default:
          eligible[i] = 1'b0;
      endcase
    end
  end

  logic                 gnt_any;
  int                   gnt_idx;
  sch_cmd_t             gnt_cmd;
  logic [ADDR_BITS-1:0] gnt_addr;
  logic                 gnt_act;
  logic                 gnt_col;

  // Downward loops leave the lowest index / smallest rotation offset as the final winner.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = 0;
    if (!bus.isu_fifo_full) begin
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
        if (eligible[i] && is_ref[i]) begin
          gnt_any = 1'b1;
          gnt_idx = i;
        end
      end
      if (!gnt_any) begin
        for (int off = NUM_BANKS - 1; off >= 0; off--) begin
          idx = (int'(rr_ptr) + off) % NUM_BANKS;
          if (eligible[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
          end
        end
      end
    end

    gnt_cmd  = gnt_any ? sch_cmd_t'(bus.req_cmd[3*gnt_idx +: 3]) : ATCMD_NOP;
    gnt_addr = gnt_any ? bus.req_addr[ADDR_BITS*gnt_idx +: ADDR_BITS] : '0;
    gnt_act  = gnt_any && (gnt_cmd == ATCMD_ACTIVE);
    gnt_col  = gnt_any && (gnt_cmd inside {ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA});
    bus.grant = gnt_any ? (NUM_BANKS'(1) << gnt_idx) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      rrd_cnt       <= '0;
      ccd_cnt       <= '0;
      for (int s = 0; s < 4; s++) faw_slot[s] <= '0;
      bus.sch_issue <= 1'b0;
      bus.sch_out   <= {ATCMD_NOP, {ADDR_BITS{1'b0}}, 3'd0};
    end else begin
      if (gnt_any) rr_ptr <= PW'((gnt_idx + 1) % NUM_BANKS);

      if (gnt_act)              rrd_cnt <= CW'(T_RRD - 1);
      else if (rrd_cnt != '0)   rrd_cnt <= rrd_cnt - CW'(1);

      if (gnt_col)              ccd_cnt <= CW'(T_CCD - 1);
      else if (ccd_cnt != '0)   ccd_cnt <= ccd_cnt - CW'(1);

      // Load wins over decrement; only the lowest free slot takes the new ACTIVE.
      for (int s = 0; s < 4; s++) begin
        if (gnt_act && (s == faw_sel))  faw_slot[s] <= CW'(T_FAW - 1);
        else if (faw_slot[s] != '0)     faw_slot[s] <= faw_slot[s] - CW'(1);
      end

      bus.sch_issue <= gnt_any;
      bus.sch_out   <= gnt_any ? {gnt_cmd, gnt_addr, 3'(gnt_idx)}
                               : {ATCMD_NOP, {ADDR_BITS{1'b0}}, 3'd0};
    end
  end

  nop_never_requested: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req_valid & is_nop) == '0)
    else $error("bank_cmd_arbiter: NOP presented with req_valid set");

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: each step checks the combinational grant and queues the
// expected issue-FIFO word, which is popped and compared after the following rising edge.
module tb_bank_cmd_arbiter;
  localparam int NB = 4;
  localparam int AB = 14;
  localparam int OW = AB + 6;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd6;
  localparam logic [2:0] C_REF = 3'd7;

  typedef struct packed {
    logic          issue;
    logic [OW-1:0] out;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NB-1:0] valid;
  logic [NB-1:0] hold;
  logic          full;
  logic [2:0]    cmd  [NB];
  logic [AB-1:0] addr [NB];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  bank_cmd_arbiter_if #(.NUM_BANKS(NB), .ADDR_BITS(AB)) bus ();

  bank_cmd_arbiter #(
    .NUM_BANKS(NB), .ADDR_BITS(AB), .T_RRD(4), .T_FAW(20), .T_CCD(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always_comb begin
    bus.req_valid     = valid;
    bus.isu_fifo_full = full;
    bus.req_cmd       = '0;
    bus.req_addr      = '0;
    for (int i = 0; i < NB; i++) begin
      bus.req_cmd[3*i +: 3]    = cmd[i];
      bus.req_addr[AB*i +: AB] = addr[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: grant checked mid-cycle, registered output checked after the edge.
  task automatic step(input logic [NB-1:0] exp_g, input string tag);
    exp_t e;
    @(negedge clk);
    check({tag, " grant"}, 32'(bus.grant), 32'(exp_g));
    e.issue = (exp_g != '0);
    e.out   = '0;
    for (int i = 0; i < NB; i++)
      if (exp_g[i]) e.out = {cmd[i], addr[i], 3'(i)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, " sch_issue"}, 32'(bus.sch_issue), 32'(e.issue));
    check({tag, " sch_out"}, 32'(bus.sch_out), 32'(e.out));
    valid = valid & ~(exp_g & ~hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    hold  = '0;
    full  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    hold  = '0;
    full  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      cmd[i]  = C_NOP;
      addr[i] = '0;
    end
    #2;
    check("reset sch_issue", 32'(bus.sch_issue), 32'd0);
    check("reset sch_out", 32'(bus.sch_out), 32'd0);
    check("reset grant", 32'(bus.grant), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mid-run reset while a push is on the output register.
    cmd[1] = C_PRE; addr[1] = 14'h0123; valid[1] = 1'b1;
    step(4'b0010, "pre_b1");
    cmd[2] = C_PRE; addr[2] = 14'h0222; valid[2] = 1'b1;
    cmd[3] = C_PRE; addr[3] = 14'h0333; valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst sch_issue", 32'(bus.sch_issue), 32'd0);
    check("midrst sch_out", 32'(bus.sch_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0100, "postrst b2");
    step(4'b1000, "postrst b3");

    // tRRD: four ACTIVEs spaced four cycles apart, then tFAW blocks the fifth.
    do_reset();
    for (int i = 0; i < NB; i++) begin
      cmd[i]  = C_ACT;
      addr[i] = AB'(14'h0100 + i);
    end
    valid = 4'b1111;
    for (int c = 0; c <= 12; c++)
      step((c % 4 == 0) ? (NB'(1) << (c / 4)) : '0, "rrd");
    cmd[0] = C_PRE; addr[0] = 14'h0abc; valid[0] = 1'b1;
    step(4'b0001, "faw pre");
    cmd[0] = C_ACT; addr[0] = 14'h1ff0; valid[0] = 1'b1;
    for (int c = 14; c < 20; c++) step(4'b0000, "faw blocked");
    step(4'b0001, "faw act");

    // Round-robin between two banks under tCCD.
    do_reset();
    cmd[1] = C_RD; addr[1] = 14'h0011;
    cmd[3] = C_RD; addr[3] = 14'h0033;
    hold  = 4'b1010;
    valid = 4'b1010;
    for (int c = 0; c <= 12; c++)
      step((c % 4 != 0) ? 4'b0000 : (((c / 4) % 2 == 0) ? 4'b0010 : 4'b1000), "rr_ccd");

    // Issue FIFO full holds off a WRITE.
    do_reset();
    cmd[0] = C_WR; addr[0] = 14'h3fff; valid = 4'b0001;
    full = 1'b1;
    for (int c = 0; c <= 5; c++) step(4'b0000, "fifo full");
    full = 1'b0;
    step(4'b0001, "fifo drain");

    // REFRESH overrides round-robin order; rr_ptr afterwards points at bank 1.
    do_reset();
    cmd[0] = C_ACT; addr[0] = 14'h0040;
    cmd[2] = C_REF; addr[2] = 14'h0000;
    valid = 4'b0101;
    step(4'b0100, "ref prio");
    step(4'b0001, "ref then act");
    cmd[0] = C_PRE; addr[0] = 14'h0050;
    cmd[1] = C_PRE; addr[1] = 14'h0051;
    valid = 4'b0011;
    step(4'b0010, "rr after ref");
    step(4'b0001, "rr wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bank_cmd_arbiter.md
# bank_cmd_arbiter

Multi-bank command arbiter between the per-bank controllers and the DRAM issue FIFO. Each cycle it selects at most one pending bank command that satisfies inter-bank timing (tRRD, tFAW, tCCD) and grants it round-robin, with refresh given priority. It registers the selected command into the issue-FIFO format `{cmd, addr, bank}` and gives each bank a one-hot grant that doubles as its inverse stall.

## Interface
- `NUM_BANKS`, default 4: number of requesting banks; a power of two, ≤ 8.
- `ADDR_BITS`, default `` `ADDR_BITS ``: command address width.
- `T_RRD`, default 4: minimum cycles between ACTIVE grants.
- `T_FAW`, default 20: rolling window that may contain at most 4 ACTIVE grants.
- `T_CCD`, default 4: minimum cycles between column-command grants (READ/WRITE/RDA/WRA).
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, NUM_BANKS: bank i has a command pending.
- `req_cmd`, in, 3×NUM_BANKS: `sch_cmd_t` for bank i, in slice [3i+2:3i].
- `req_addr`, in, ADDR_BITS×NUM_BANKS: address for bank i.
- `isu_fifo_full`, in, 1: issue FIFO full; it asserts while at least 1 entry is still free.
- `grant`, out, NUM_BANKS: one-hot and combinational; the bank's request is consumed at the next rising edge.
- `sch_issue`, out, 1: registered push strobe to the issue FIFO.
- `sch_out`, out, 3+ADDR_BITS+3: registered `{cmd, addr, bank}`, with the bank index zero-extended to 3 bits.

## Operation
- **Eligibility** (eligible[i] = req_valid[i] and the command's class rule):
  - ACTIVE requires `rrd_cnt==0` and at least one free tFAW slot.
  - READ/WRITE/RDA/WRA require `ccd_cnt==0`.
  - PRECHARGE and REFRESH are always eligible.
  - NOP with req_valid set is never granted; flag it as an assertion error.
- **Selection:**
  - If `isu_fifo_full` is high, grant = 0.
  - Otherwise, if any eligible request is REFRESH, grant the lowest-index eligible REFRESH.
  - Otherwise, grant the first eligible bank searching upward from `rr_ptr` with wrap-around.
  - If nothing is eligible, grant = 0.
- **rr_ptr:** on any grant to bank k, `rr_ptr <= (k+1) mod NUM_BANKS`. It is unchanged when there is no grant.
- **rrd_cnt:** loads T_RRD−1 on an ACTIVE grant; otherwise decrements, saturating at 0.
- **ccd_cnt:** loads T_CCD−1 on a column-command grant; otherwise decrements, saturating at 0.
- **tFAW:** tracked by 4 down-counters (`faw_slot[0..3]`).
  - An ACTIVE grant loads T_FAW−1 into the lowest-index zero slot.
  - Nonzero slots decrement every cycle.
  - A free slot exists iff any slot equals 0.
- **Output register:**
  - On a grant: `sch_issue <= 1` and `sch_out <= {req_cmd[k], req_addr[k], k}`.
  - With no grant: `sch_issue <= 0`, and `sch_out` holds `{ATCMD_NOP, 0, 0}`.
- **Simultaneous events:**
  - A grant and a counter reaching 0 in the same cycle is handled by load taking precedence over decrement.
  - A request deasserted in the same cycle it would be granted is simply not granted, because grant depends on req_valid in that cycle.

## Timing
- Reset (asynchronous, immediate):
  - `rr_ptr=0`; `rrd_cnt`, `ccd_cnt` and all `faw_slot` = 0.
  - `sch_issue=0`, `sch_out={ATCMD_NOP,0,0}`.
  - `grant` is 0 whenever req_valid is 0.
- Latency: grant in cycle n produces `sch_issue` high in cycle n+1, exactly 1 cycle later.
- Timing spacing for a grant in cycle n:
  - Next ACTIVE is eligible at n+T_RRD.
  - Next column command is eligible at n+T_CCD.
  - The tFAW slot loaded at n frees at n+T_FAW.
- Reset asserted mid-operation: the in-flight `sch_out` is dropped and counters clear. Banks keep their requests asserted and re-arbitrate after `rst_n` deasserts, starting from bank 0.
- `isu_fifo_full` is sampled combinationally in the grant cycle. The FIFO's 1-entry slack absorbs the registered push in the following cycle.

## Test plan
All scenarios use NUM_BANKS=4, T_RRD=4, T_FAW=20, T_CCD=4.
- **Reset:** `rst_n` low mid-run with `sch_issue=1` -> `sch_issue=0` and `sch_out={ATCMD_NOP,0,0}` immediately. After release, with banks 2 and 3 both requesting PRECHARGE, bank 2 is granted first.
- **tRRD:** banks 0–3 each request ACTIVE from cycle 0 -> grants at cycles 0, 4, 8, 12 to banks 0, 1, 2, 3; `sch_issue` at cycles 1, 5, 9, 13 with bank fields 0–3.
- **tFAW:** after the scenario above, bank 0 requests PRECHARGE at cycle 13 (granted at 13) and ACTIVE from cycle 14 -> ACTIVE granted at cycle 20, not at 16.
- **Round-robin and tCCD:** banks 1 and 3 hold READ requests continuously from cycle 0 -> grants 1, 3, 1, 3 at cycles 0, 4, 8, 12; no column grant in between.
- **FIFO full:** bank 0 holds WRITE and `isu_fifo_full` is high during cycles 0–5 -> grant=0 and `sch_issue=0` through cycle 6; grant at cycle 6, `sch_issue` at cycle 7.
- **Refresh priority:** `rr_ptr=0`, bank 0 requests ACTIVE and bank 2 requests REFRESH in the same cycle -> bank 2 granted with cmd ATCMD_REFRESH; bank 0 granted the next cycle; `rr_ptr` ends at 1.
